// File: rtl/prbs31_pkg.sv
// rtl/prbs31_pkg.sv - shared states, PRBS31 taps and relock constants for the BERT sequencer
package prbs31_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HUNT,
    RUN,
    DONE
  } state_e;

  localparam int PRBS_LEN   = 31;
  localparam int TAP_A      = 30;
  localparam int TAP_B      = 27;
  localparam int RELOCK_BLK = 32;
  localparam int RELOCK_THR = 8;

  function automatic logic prbs_next(input logic [PRBS_LEN-1:0] sr);
    return sr[TAP_A] ^ sr[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - PRBS31 receive checker, self-synchronising or free-running
module prbs31_checker
  import prbs31_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic bit_i,
  input  logic valid,
  input  logic self_sync,
  output logic err,
  output logic filled
);

  logic [PRBS_LEN-1:0] sr_q, sr_d;
  logic [4:0]          fill_q, fill_d;
  logic                pred;

  assign pred   = prbs_next(sr_q);
  assign filled = (fill_q == 5'(PRBS_LEN));
  // An all-zero register is the LFSR lock-up state; a stuck-low line must never look locked.
  assign err    = filled & ((bit_i ^ pred) | (sr_q == '0));

  always_comb begin
    sr_d   = sr_q;
    fill_d = fill_q;
    if (clr) begin
      sr_d   = '0;
      fill_d = '0;
    end else if (valid) begin
      sr_d = {sr_q[PRBS_LEN-2:0], (self_sync ? bit_i : pred)};
      if (!filled) fill_d = fill_q + 5'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/prbs31_bert_ctrl.sv
// rtl/prbs31_bert_ctrl.sv - PRBS31 bit-error-rate test sequencer; PRBS_RELOCK_EN adds block-error relock
module prbs31_bert_ctrl
  import prbs31_pkg::*;
#(
  parameter int                  CNT_W        = 24,
  parameter int                  ERR_W        = 16,
  parameter logic [PRBS_LEN-1:0] SEED         = 31'h7FFF_FFFF,
  parameter int                  LOCK_BITS    = 64,
  parameter int                  SYNC_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    run_len,
  output logic                gen_load,
  output logic [PRBS_LEN-1:0] gen_seed,
  output logic                gen_en,
  input  logic                rx_bit,
  input  logic                rx_valid,
  output logic                busy,
  output logic                locked,
  output logic                done,
  output logic                sync_fail,
  output logic [CNT_W-1:0]    bit_cnt,
  output logic [ERR_W-1:0]    err_cnt
`ifdef PRBS_RELOCK_EN
  ,
  output logic [7:0]          relock_cnt
`endif
);

  localparam int HUNT_W  = $clog2(SYNC_TIMEOUT + 1);
  localparam int MATCH_W = $clog2(LOCK_BITS + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               sync_fail_q, sync_fail_d;
  logic [HUNT_W-1:0]  hunt_cnt_q, hunt_cnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               chk_clr, chk_valid, chk_err, chk_filled;

`ifdef PRBS_RELOCK_EN
  localparam int BLK_W = $clog2(RELOCK_BLK);
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [3:0]       blk_err_q, blk_err_d;
  logic [7:0]       relock_cnt_q, relock_cnt_d;
  logic             relock_hit;
  assign relock_cnt = relock_cnt_q;
`endif

  assign chk_valid = rx_valid & ~abort & ((state_q == HUNT) | (state_q == RUN));

  prbs31_checker u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (chk_clr),
    .bit_i     (rx_bit),
    .valid     (chk_valid),
    .self_sync (state_q == HUNT),
    .err       (chk_err),
    .filled    (chk_filled)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    sync_fail_d = sync_fail_q;
    hunt_cnt_d  = hunt_cnt_q;
    match_d     = match_q;
    chk_clr     = 1'b0;
`ifdef PRBS_RELOCK_EN
    blk_cnt_d    = blk_cnt_q;
    blk_err_d    = blk_err_q;
    relock_cnt_d = relock_cnt_q;
    relock_hit   = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (start) begin
        state_d     = LOAD;
        bit_cnt_d   = '0;
        err_cnt_d   = '0;
        sync_fail_d = 1'b0;
`ifdef PRBS_RELOCK_EN
        relock_cnt_d = '0;
`endif
      end
      LOAD: begin
        state_d    = HUNT;
        hunt_cnt_d = '0;
        match_d    = '0;
        chk_clr    = 1'b1;
      end
      HUNT: if (rx_valid) begin
        hunt_cnt_d = hunt_cnt_q + HUNT_W'(1);
        if (chk_filled) match_d = chk_err ? '0 : match_q + MATCH_W'(1);
        if (match_d == MATCH_W'(LOCK_BITS)) begin
          state_d = RUN;
`ifdef PRBS_RELOCK_EN
          blk_cnt_d = '0;
          blk_err_d = '0;
`endif
        end else if (hunt_cnt_d == HUNT_W'(SYNC_TIMEOUT)) begin
          sync_fail_d = 1'b1;
          state_d     = DONE;
        end
      end
      RUN: if (run_len == '0) begin
        state_d = DONE;
      end else if (rx_valid) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (chk_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
`ifdef PRBS_RELOCK_EN
        blk_cnt_d  = blk_cnt_q + BLK_W'(1);
        blk_err_d  = blk_err_q + 4'(chk_err);
        relock_hit = (blk_err_d >= 4'(RELOCK_THR));
        if (blk_cnt_q == BLK_W'(RELOCK_BLK - 1)) blk_err_d = '0;
`endif
        if (bit_cnt_d == run_len) begin
          state_d = DONE;
        end
`ifdef PRBS_RELOCK_EN
        else if (relock_hit) begin
          state_d    = HUNT;
          hunt_cnt_d = '0;
          match_d    = '0;
          if (relock_cnt_q != '1) relock_cnt_d = relock_cnt_q + 8'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      bit_cnt_d   = bit_cnt_q;
      err_cnt_d   = err_cnt_q;
      sync_fail_d = sync_fail_q;
`ifdef PRBS_RELOCK_EN
      relock_cnt_d = relock_cnt_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      sync_fail_q <= 1'b0;
      hunt_cnt_q  <= '0;
      match_q     <= '0;
`ifdef PRBS_RELOCK_EN
      blk_cnt_q    <= '0;
      blk_err_q    <= '0;
      relock_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      sync_fail_q <= sync_fail_d;
      hunt_cnt_q  <= hunt_cnt_d;
      match_q     <= match_d;
`ifdef PRBS_RELOCK_EN
      blk_cnt_q    <= blk_cnt_d;
      blk_err_q    <= blk_err_d;
      relock_cnt_q <= relock_cnt_d;
`endif
    end
  end

  assign gen_load  = (state_q == LOAD);
  assign gen_seed  = SEED;
  assign gen_en    = (state_q == HUNT) | (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign locked    = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sync_fail = sync_fail_q;
  assign bit_cnt   = bit_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs31_bert_ctrl.sv
// tb/tb_prbs31_bert_ctrl.sv - scoreboard bench for prbs31_bert_ctrl with a looped-back PRBS31 generator model
module tb_prbs31_bert_ctrl;

  localparam int          CNT_W = 24;
  localparam int          ERR_W = 16;
  localparam logic [30:0] SEED  = 31'h7FFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             rx_valid = 1'b0;
  logic             tie0 = 1'b0;
  logic             inj = 1'b0;
  logic [CNT_W-1:0] run_len = '0;
  logic             rx_bit;
  logic             gen_load, gen_en, busy, locked, done, sync_fail;
  logic [30:0]      gen_seed;
  logic [CNT_W-1:0] bit_cnt;
  logic [ERR_W-1:0] err_cnt;
`ifdef PRBS_RELOCK_EN
  logic [7:0]       relock_cnt;
`endif

  logic [30:0] gen_sr;
  bit          inj_map [0:2047];
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    int bit_cnt;
    int err_cnt;
    bit sync_fail;
    bit done;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  prbs31_bert_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .run_len   (run_len),
    .gen_load  (gen_load),
    .gen_seed  (gen_seed),
    .gen_en    (gen_en),
    .rx_bit    (rx_bit),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .locked    (locked),
    .done      (done),
    .sync_fail (sync_fail),
    .bit_cnt   (bit_cnt),
    .err_cnt   (err_cnt)
`ifdef PRBS_RELOCK_EN
    ,
    .relock_cnt(relock_cnt)
`endif
  );

  // Generator and loopback channel: x^31+x^28+1 seeded on gen_load, optional bit flip or stuck-low line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 gen_sr <= '0;
    else if (gen_load)          gen_sr <= gen_seed;
    else if (gen_en && rx_valid) gen_sr <= {gen_sr[29:0], gen_sr[30] ^ gen_sr[27]};
  end
  assign rx_bit = tie0 ? 1'b0 : ((gen_sr[30] ^ gen_sr[27]) ^ inj);

  task automatic session(input int rl, input bit toggle, input int abort_at,
                         output bit saw_done, output bit saw_lock, output int lock_bits,
                         output int lock_to_done, output int hunt_total, output bit gl_first,
                         output int cnt_first, output int abort_lat, output bit timed_out);
    int run_bits, post_bits, lock_cyc, abort_cyc;
    bit v;
    saw_done = 0; saw_lock = 0; lock_bits = -1; lock_to_done = -1; hunt_total = 0;
    abort_lat = -1; timed_out = 1; run_bits = 0; post_bits = 0; lock_cyc = 0; abort_cyc = -1; v = 0;
    @(negedge clk);
    run_len = CNT_W'(rl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gl_first = gen_load;
    cnt_first = int'(bit_cnt);
    for (int c = 0; c < 6000; c++) begin
      if (done) begin
        saw_done = 1;
        if (saw_lock) lock_to_done = c - lock_cyc;
        timed_out = 0;
        break;
      end
      if (!busy) begin
        if (abort_cyc >= 0) abort_lat = c - abort_cyc;
        timed_out = 0;
        break;
      end
      if (locked && !saw_lock) begin
        saw_lock = 1;
        lock_bits = hunt_total;
        lock_cyc = c;
      end
      v = toggle ? !v : 1'b1;
      rx_valid = v;
      abort = 1'b0;
      inj = 1'b0;
      if (abort_at >= 0 && locked && run_bits == abort_at && abort_cyc < 0) begin
        abort = 1'b1;
        rx_valid = 1'b0;
        abort_cyc = c;
      end else if (rx_valid && gen_en) begin
        if (saw_lock) begin
          if (post_bits < 2048) inj = inj_map[post_bits];
          post_bits++;
          if (locked) run_bits++;
        end else begin
          hunt_total++;
        end
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    abort = 1'b0;
    inj = 1'b0;
  endtask

  task automatic clear_inj();
    foreach (inj_map[i]) inj_map[i] = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({busy, gen_load, gen_en, locked, done, sync_fail} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 000000", {busy, gen_load, gen_en, locked, done, sync_fail});
    end
    tests++;
    if (bit_cnt !== '0 || err_cnt !== '0) begin
      fails++;
      $display("FAIL reset_counters got bit=%0d err=%0d want 0/0", bit_cnt, err_cnt);
    end
    tests++;
    if (gen_seed !== SEED) begin
      fails++;
      $display("FAIL reset_seed got %h want %h", gen_seed, SEED);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_pass();
    bit sd, sl, gl, to; int lb, ld, ht, cf, al; exp_t e;
    clear_inj();
    exp_q.push_back('{1000, 0, 0, 1});
    session(1000, 0, -1, sd, sl, lb, ld, ht, gl, cf, al, to);
    tests++;
    if (to !== 0) begin fails++; $display("FAIL basic_timeout got %0b want 0", to); end
    tests++;
    if (gl !== 1'b1) begin fails++; $display("FAIL basic_gen_load_latency got %0b want 1", gl); end
    tests++;
    if (lb !== 95) begin fails++; $display("FAIL basic_lock_bits got %0d want 95", lb); end
    e = exp_q.pop_front();
    tests++;
    if (int'(bit_cnt) !== e.bit_cnt || int'(err_cnt) !== e.err_cnt) begin
      fails++;
      $display("FAIL basic_counts got bit=%0d err=%0d want %0d/%0d", bit_cnt, err_cnt, e.bit_cnt, e.err_cnt);
    end
    tests++;
    if (sync_fail !== e.sync_fail || sd !== e.done) begin
      fails++;
      $display("FAIL basic_status got sf=%0b done=%0b want %0b/%0b", sync_fail, sd, e.sync_fail, e.done);
    end
  endtask

  task automatic test_single_errors();
    bit sd, sl, gl, to; int lb, ld, ht, cf, al; exp_t e;
    clear_inj();
    inj_map[100] = 1; inj_map[500] = 1; inj_map[900] = 1;
    exp_q.push_back('{1000, 3, 0, 1});
    session(1000, 0, -1, sd, sl, lb, ld, ht, gl, cf, al, to);
    clear_inj();
    tests++;
    if (to !== 0) begin fails++; $display("FAIL errors_timeout got %0b want 0", to); end
    e = exp_q.pop_front();
    tests++;
    if (int'(bit_cnt) !== e.bit_cnt || int'(err_cnt) !== e.err_cnt) begin
      fails++;
      $display("FAIL errors_counts got bit=%0d err=%0d want %0d/%0d", bit_cnt, err_cnt, e.bit_cnt, e.err_cnt);
    end
    tests++;
    if (sync_fail !== e.sync_fail || sd !== e.done) begin
      fails++;
      $display("FAIL errors_status got sf=%0b done=%0b want %0b/%0b", sync_fail, sd, e.sync_fail, e.done);
    end
  endtask

  task automatic test_async_reset();
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (bit_cnt !== '0 || err_cnt !== '0) begin
      fails++;
      $display("FAIL areset_idle_counters got bit=%0d err=%0d want 0/0", bit_cnt, err_cnt);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_len = CNT_W'(1000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rx_valid = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || gen_en !== 1'b1 || locked !== 1'b0) begin
      fails++;
      $display("FAIL areset_pre_hunt got busy=%0b gen_en=%0b locked=%0b want 1/1/0", busy, gen_en, locked);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, gen_load, gen_en, locked, done, sync_fail} !== 6'b0 || gen_seed !== SEED) begin
      fails++;
      $display("FAIL areset_mid_hunt got flags=%b seed=%h want 000000/%h",
               {busy, gen_load, gen_en, locked, done, sync_fail}, gen_seed, SEED);
    end
    #1 rst_n = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sync_fail();
    bit sd, sl, gl, to; int lb, ld, ht, cf, al; exp_t e;
    clear_inj();
    tie0 = 1'b1;
    exp_q.push_back('{0, 0, 1, 1});
    session(1000, 0, -1, sd, sl, lb, ld, ht, gl, cf, al, to);
    tie0 = 1'b0;
    tests++;
    if (to !== 0) begin fails++; $display("FAIL syncfail_timeout got %0b want 0", to); end
    tests++;
    if (sl !== 0) begin fails++; $display("FAIL syncfail_locked got %0b want 0", sl); end
    tests++;
    if (ht !== 4096) begin fails++; $display("FAIL syncfail_hunt_bits got %0d want 4096", ht); end
    e = exp_q.pop_front();
    tests++;
    if (sync_fail !== e.sync_fail || sd !== e.done || int'(bit_cnt) !== e.bit_cnt) begin
      fails++;
      $display("FAIL syncfail_status got sf=%0b done=%0b bit=%0d want %0b/%0b/%0d",
               sync_fail, sd, bit_cnt, e.sync_fail, e.done, e.bit_cnt);
    end
  endtask

  task automatic test_abort_restart();
    bit sd, sl, gl, to; int lb, ld, ht, cf, al; exp_t e;
    clear_inj();
    exp_q.push_back('{200, 0, 0, 0});
    session(1000, 0, 200, sd, sl, lb, ld, ht, gl, cf, al, to);
    tests++;
    if (to !== 0 || al !== 1) begin fails++; $display("FAIL abort_latency got %0d (timeout=%0b) want 1", al, to); end
    e = exp_q.pop_front();
    tests++;
    if (int'(bit_cnt) !== e.bit_cnt || sd !== e.done) begin
      fails++;
      $display("FAIL abort_counts got bit=%0d done=%0b want %0d/%0b", bit_cnt, sd, e.bit_cnt, e.done);
    end
    exp_q.push_back('{1000, 0, 0, 1});
    session(1000, 0, -1, sd, sl, lb, ld, ht, gl, cf, al, to);
    tests++;
    if (cf !== 0) begin fails++; $display("FAIL restart_clear got bit=%0d want 0", cf); end
    e = exp_q.pop_front();
    tests++;
    if (int'(bit_cnt) !== e.bit_cnt || int'(err_cnt) !== e.err_cnt || sd !== e.done || to !== 0) begin
      fails++;
      $display("FAIL restart_pass got bit=%0d err=%0d done=%0b want %0d/%0d/%0b",
               bit_cnt, err_cnt, sd, e.bit_cnt, e.err_cnt, e.done);
    end
  endtask

  task automatic test_toggle_runlen0();
    bit sd, sl, gl, to; int lb, ld, ht, cf, al; exp_t e;
    clear_inj();
    exp_q.push_back('{0, 0, 0, 1});
    session(0, 1, -1, sd, sl, lb, ld, ht, gl, cf, al, to);
    tests++;
    if (lb !== 95) begin fails++; $display("FAIL toggle_lock_bits got %0d want 95", lb); end
    tests++;
    if (ld !== 1) begin fails++; $display("FAIL runlen0_lock_to_done got %0d want 1", ld); end
    e = exp_q.pop_front();
    tests++;
    if (int'(bit_cnt) !== e.bit_cnt || sd !== e.done || to !== 0) begin
      fails++;
      $display("FAIL runlen0_counts got bit=%0d done=%0b want %0d/%0b", bit_cnt, sd, e.bit_cnt, e.done);
    end
  endtask

`ifdef PRBS_RELOCK_EN
  task automatic test_relock();
    bit sd, sl, gl, to; int lb, ld, ht, cf, al; exp_t e;
    clear_inj();
    for (int i = 300; i < 310; i++) inj_map[i] = 1;
    exp_q.push_back('{1000, 8, 0, 1});
    session(1000, 0, -1, sd, sl, lb, ld, ht, gl, cf, al, to);
    clear_inj();
    tests++;
    if (relock_cnt !== 8'd1) begin fails++; $display("FAIL relock_cnt got %0d want 1", relock_cnt); end
    e = exp_q.pop_front();
    tests++;
    if (int'(bit_cnt) !== e.bit_cnt || int'(err_cnt) !== e.err_cnt || sd !== e.done || to !== 0) begin
      fails++;
      $display("FAIL relock_counts got bit=%0d err=%0d done=%0b want %0d/%0d/%0b",
               bit_cnt, err_cnt, sd, e.bit_cnt, e.err_cnt, e.done);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_pass();
    test_single_errors();
    test_async_reset();
    test_sync_fail();
    test_abort_restart();
    test_toggle_runlen0();
`ifdef PRBS_RELOCK_EN
    test_relock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prbs31_bert_ctrl.md
Name: prbs31_bert_ctrl

Overview:
Bit-error-rate test sequencer for the PRBS31 datapath (polynomial x^31+x^28+1).
- Seeds and enables the PRBS31 generator.
- Hunts for lock on the returned bit stream, then counts received bits and errors for a programmed run length.
- Reports the result; sits between the top-level pin wrapper and the generator/loopback path.

Parameters:
CNT_W, 24, width of run-length and bit counters
ERR_W, 16, width of saturating error counter
SEED, 31'h7FFF_FFFF, value driven on gen_seed during LOAD; must be non-zero
LOCK_BITS, 64, consecutive error-free checked bits required to declare lock
SYNC_TIMEOUT, 4096, rx_valid bits allowed in HUNT before declaring sync failure

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin test; sampled only in IDLE
abort  in  1  return to IDLE from any state, no done pulse
run_len  in  CNT_W  number of checked bits in RUN; 0 means DONE on entry to RUN
gen_load  out  1  one-cycle seed load strobe to generator
gen_seed  out  31  seed value, constant SEED
gen_en  out  1  generator shift enable
rx_bit  in  1  received bit from loopback
rx_valid  in  1  rx_bit qualifier
busy  out  1  high in any state except IDLE
locked  out  1  high in RUN only
done  out  1  one-cycle pulse on test completion (pass or sync fail)
sync_fail  out  1  sticky until next start; set on HUNT timeout
bit_cnt  out  CNT_W  bits checked in RUN
err_cnt  out  ERR_W  errors in RUN, saturates at all-ones

Behaviour:
- Reset: FSM=IDLE; every output 0 except gen_seed=SEED; checker register 0.
- States:
  - IDLE: start=1 -> LOAD; clear bit_cnt, err_cnt, sync_fail.
  - LOAD: gen_load=1 for exactly one cycle -> HUNT.
  - HUNT: gen_en=1. Each rx_valid bit shifts into the 31-bit checker register (self-synchronising). After the first 31 bits the checker compares rx_bit with sr[30]^sr[27].
    - Match: increments the match run.
    - Mismatch: clears the match run.
    - Match run reaching LOCK_BITS: -> RUN next cycle.
    - Hunt bit count reaching SYNC_TIMEOUT without lock: sync_fail=1 -> DONE.
  - RUN: gen_en=1, locked=1. Checker switches to free-running mode: it shifts in its own predicted bit, so a single channel error counts once, not three times.
    - Each rx_valid: bit_cnt+1; on mismatch, err_cnt+1 (saturating).
    - When bit_cnt equals run_len after an increment: -> DONE. run_len=0 takes RUN -> DONE in one cycle.
  - DONE: done=1 for one cycle, gen_en=0 -> IDLE. Counters and sync_fail hold until the next start.
- rx_valid=0: no state, counter or checker change; timeout does not advance.
- abort wins over every other transition. Counters hold their values; busy falls the next cycle.
- start while busy is ignored.
- bit_cnt never wraps: run_len bounds it.
- Latency: start to gen_load is 1 cycle. The last counted bit to the done pulse is 1 cycle.
- Async reset mid-test: immediate IDLE; outputs take their reset values.

Optional Feature:
- Macro: PRBS_RELOCK_EN.
- Defined:
  - RUN counts errors in consecutive 32-bit blocks.
  - 8 or more errors in one block -> return to HUNT, match run cleared, bit_cnt/err_cnt retained, relock_cnt output (8-bit, saturating) incremented.
  - HUNT timeout still leads to sync_fail.
- Undefined: no block error counter, no relock_cnt port; RUN only exits via run_len or abort.

Decomposition:
- Package prbs31_pkg:
  - state enum (IDLE, LOAD, HUNT, RUN, DONE);
  - PRBS_LEN=31, TAP_A=30, TAP_B=27;
  - relock block size 32 and threshold 8.
- Sub-module prbs31_checker: 31-bit register with inputs bit, valid, self_sync; outputs err and filled.
- The controller FSM and counters stay in prbs31_bert_ctrl.

Test Plan:
1. Bench PRBS31 model seeded on gen_load, looped to rx_bit with rx_valid=1, run_len=1000 -> lock after 31+64 bits, done pulse, bit_cnt=1000, err_cnt=0, sync_fail=0.
2. Same, with rx_bit inverted at RUN bits 100, 500 and 900 -> err_cnt=3 (not 9), bit_cnt=1000.
3. rx_bit tied to 0 -> after 4096 hunt bits sync_fail=1, done pulse, locked never high.
4. abort asserted mid-RUN at bit 200 -> IDLE next cycle, no done, bit_cnt=200. Then start again -> counters clear and a normal pass follows.
5. rx_valid toggling 1/0 every cycle, run_len=0 -> done 1 cycle after lock, bit_cnt=0. Separately, rst_n pulsed low mid-HUNT -> all outputs reset asynchronously.
6. PRBS_RELOCK_EN defined: 10 consecutive errors injected at RUN bit 300 -> HUNT, relock_cnt=1, relock succeeds, done with bit_cnt=run_len.
